// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO bridge: register offsets, STATUS bit
// positions and the default FIFO depth.
package uart_mmio_pkg;

    // Default number of entries in each of the RX and TX FIFOs.
    localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

    // Byte offsets within the UART window.
    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_RX     = 4'h4;
    localparam logic [3:0] ADDR_TX     = 4'h8;

    // Word indices (offset bits [3:2]); the byte-lane bits are ignored.
    localparam logic [1:0] IDX_STATUS = ADDR_STATUS[3:2];
    localparam logic [1:0] IDX_RX     = ADDR_RX[3:2];
    localparam logic [1:0] IDX_TX     = ADDR_TX[3:2];

    // STATUS register bit positions.
    localparam int unsigned STAT_TX_NOT_FULL  = 0;
    localparam int unsigned STAT_RX_NOT_EMPTY = 1;
    localparam int unsigned STAT_TX_OVF       = 2;
    localparam int unsigned STAT_RX_COUNT_LSB = 8;
    localparam int unsigned STAT_TX_COUNT_LSB = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with ready/valid on both sides.
//   clk, reset      : clock and synchronous active-high reset
//   in_data         : write data
//   in_valid        : producer offers in_data
//   in_ready_c      : FIFO not full (combinational from occupancy register)
//   out_data_c      : head entry, read combinationally from storage
//   out_valid_c     : FIFO not empty (combinational from occupancy register)
//   out_ready       : consumer takes the head entry this cycle
//   count           : current occupancy, 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready_c,
    output logic [WIDTH-1:0]         out_data_c,
    output logic                     out_valid_c,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push_c;
    logic             pop_c;

    // Handshake flags come straight from the registered occupancy, so a
    // full FIFO refuses a push even when a pop happens in the same cycle,
    // and an empty FIFO never pops a same-cycle push.
    assign in_ready_c  = (count_q != CNT_W'(DEPTH));
    assign out_valid_c = (count_q != '0);
    assign out_data_c  = mem[rd_ptr];
    assign count       = count_q;

    assign push_c = in_valid && in_ready_c;
    assign pop_c  = out_valid_c && out_ready;

    // Pointers wrap modulo DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// CPU-side memory-mapped front end for the UART byte core. Received bytes
// are buffered in an RX FIFO, bytes to send in a TX FIFO; software sees a
// STATUS register, an RX_DATA pop register and a TX_DATA push register.
//   clk, reset      : clock and synchronous active-high reset
//   mmio_addr       : byte offset in the UART window ([1:0] ignored)
//   mmio_wdata      : store data
//   mmio_we         : store strobe, one cycle per store
//   mmio_re         : load strobe, one cycle per load
//   mmio_rdata      : load data, registered, valid the cycle after mmio_re
//   uart_tx_data    : TX head byte to the UART transmitter
//   uart_tx_valid   : TX FIFO non-empty
//   uart_tx_ready   : transmitter accepts uart_tx_data
//   uart_rx_data    : byte from the UART receiver
//   uart_rx_valid   : receiver offers uart_rx_data
//   uart_rx_ready   : RX FIFO has room
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mmio_addr,
    input  logic [31:0] mmio_wdata,
    input  logic        mmio_we,
    input  logic        mmio_re,
    output logic [31:0] mmio_rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       word_idx;
    logic             sel_status;
    logic             sel_rx;
    logic             sel_tx;

    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] tx_count;
    logic [7:0]       rx_head;
    logic             rx_not_empty;
    logic             rx_pop_req_c;
    logic             tx_not_full;
    logic             tx_push_c;
    logic             tx_drop_c;
    logic             ovf_clear_c;
    logic             tx_overflow;

    logic [31:0]      status_word;
    logic [31:0]      rdata_next;
    logic             unused_bits;

    // Address decode on word index only.
    assign word_idx   = mmio_addr[3:2];
    assign sel_status = (word_idx == IDX_STATUS);
    assign sel_rx     = (word_idx == IDX_RX);
    assign sel_tx     = (word_idx == IDX_TX);

    // The RX FIFO only pops when non-empty, so an empty read has no side effect.
    assign rx_pop_req_c = mmio_re && sel_rx;
    assign tx_push_c    = mmio_we && sel_tx;
    assign tx_drop_c    = tx_push_c && !tx_not_full;
    assign ovf_clear_c  = mmio_we && sel_status && mmio_wdata[STAT_TX_OVF];

    assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:8]};

    // Receive path: UART receiver -> RX FIFO -> RX_DATA loads.
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .in_data     (uart_rx_data),
        .in_valid    (uart_rx_valid),
        .in_ready_c  (uart_rx_ready),
        .out_data_c  (rx_head),
        .out_valid_c (rx_not_empty),
        .out_ready   (rx_pop_req_c),
        .count       (rx_count)
    );

    // Transmit path: TX_DATA stores -> TX FIFO -> UART transmitter.
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .in_data     (mmio_wdata[7:0]),
        .in_valid    (tx_push_c),
        .in_ready_c  (tx_not_full),
        .out_data_c  (uart_tx_data),
        .out_valid_c (uart_tx_valid),
        .out_ready   (uart_tx_ready),
        .count       (tx_count)
    );

    // Sticky overflow: a dropped store sets it and wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_overflow <= 1'b0;
        end else if (tx_drop_c) begin
            tx_overflow <= 1'b1;
        end else if (ovf_clear_c) begin
            tx_overflow <= 1'b0;
        end
    end

    // STATUS image built from pre-update state.
    always_comb begin
        status_word                                  = '0;
        status_word[STAT_TX_NOT_FULL]                = tx_not_full;
        status_word[STAT_RX_NOT_EMPTY]               = rx_not_empty;
        status_word[STAT_TX_OVF]                     = tx_overflow;
        status_word[STAT_RX_COUNT_LSB +: CNT_W]      = rx_count;
        status_word[STAT_TX_COUNT_LSB +: CNT_W]      = tx_count;
    end

    // Read mux; TX_DATA and the reserved offset read as zero.
    always_comb begin
        rdata_next = '0;
        if (sel_status) begin
            rdata_next = status_word;
        end else if (sel_rx && rx_not_empty) begin
            rdata_next = {24'd0, rx_head};
        end
    end

    // Load data is captured on the strobe and held until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            mmio_rdata <= '0;
        end else if (mmio_re) begin
            mmio_rdata <= rdata_next;
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Scoreboard bench for uart_mmio_bridge: directed scenarios followed by a
// randomized phase, all checked against a queue-based behavioural model.
module tb_uart_mmio_bridge;

    localparam int D = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  mmio_addr;
    logic [31:0] mmio_wdata;
    logic        mmio_we;
    logic        mmio_re;
    logic [31:0] mmio_rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    uart_mmio_bridge #(.FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .mmio_addr     (mmio_addr),
        .mmio_wdata    (mmio_wdata),
        .mmio_we       (mmio_we),
        .mmio_re       (mmio_re),
        .mmio_rdata    (mmio_rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    bit          ovf;
    // Scoreboard queues
    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];

    int n_cmp = 0;
    int n_fail = 0;
    int tx_fires = 0;
    bit mon_en = 0;
    bit re_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [3:0] off;
        off = a & 4'hC;
        if (off == 4'h0)
            return 32'(txq.size() < D) | (32'(rxq.size() > 0) << 1) | (32'(ovf) << 2)
                 | (32'(rxq.size()) << 8) | (32'(txq.size()) << 16);
        if (off == 4'h4)
            return (rxq.size() > 0) ? 32'(rxq[0]) : 32'd0;
        return 32'd0;
    endfunction

    // Advance the model by one clock using the inputs that were just applied.
    task automatic model_step();
        bit tx_pop, tx_full, tx_wr, rx_pop, rx_push, clr;
        if (reset) begin
            rxq.delete();
            txq.delete();
            exp_tx.delete();
            ovf = 0;
            return;
        end
        tx_pop  = (txq.size() != 0) && uart_tx_ready;
        tx_full = (txq.size() == D);
        tx_wr   = mmio_we && ((mmio_addr & 4'hC) == 4'h8);
        rx_pop  = mmio_re && ((mmio_addr & 4'hC) == 4'h4) && (rxq.size() != 0);
        rx_push = uart_rx_valid && (rxq.size() < D);
        clr     = mmio_we && ((mmio_addr & 4'hC) == 4'h0) && mmio_wdata[2];
        if (tx_pop) void'(txq.pop_front());
        if (tx_wr && !tx_full) begin
            txq.push_back(mmio_wdata[7:0]);
            exp_tx.push_back(mmio_wdata[7:0]);
        end
        if (rx_pop) void'(rxq.pop_front());
        if (rx_push) rxq.push_back(uart_rx_data);
        if (tx_wr && tx_full) ovf = 1;
        else if (clr) ovf = 0;
    endtask

    // One clock with the currently driven inputs; returns just after the edge.
    task automatic tick();
        if (mmio_re && !reset) exp_rd.push_back(model_read(mmio_addr));
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic load(input logic [3:0] a);
        mmio_addr = a;
        mmio_re   = 1'b1;
        tick();
        mmio_re   = 1'b0;
    endtask

    task automatic store(input logic [3:0] a, input logic [31:0] d);
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_we    = 1'b1;
        tick();
        mmio_we    = 1'b0;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (re_prev) begin
                if (exp_rd.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rdata_unexpected: got 0x%08h expected no load", mmio_rdata);
                end else begin
                    check("rdata", mmio_rdata, exp_rd.pop_front());
                end
            end
            re_prev = mmio_re && !reset;
            check("tx_valid", 32'(uart_tx_valid), 32'(txq.size() != 0));
            check("rx_ready", 32'(uart_rx_ready), 32'(rxq.size() < D));
            if (txq.size() != 0) check("tx_head", 32'(uart_tx_data), 32'(txq[0]));
            if (uart_tx_valid && uart_tx_ready && !reset) begin
                tx_fires++;
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL tx_byte_unexpected: got 0x%02h expected none", uart_tx_data);
                end else begin
                    check("tx_byte", 32'(uart_tx_data), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fires0;
        reset         = 1'b1;
        mmio_addr     = 4'h0;
        mmio_wdata    = 32'h0;
        mmio_we       = 1'b0;
        mmio_re       = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_data  = 8'h0;
        uart_rx_valid = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1;

        // Reset state
        load(4'h0);
        check("reset_status", mmio_rdata, 32'h0000_0001);
        check("reset_rx_ready", 32'(uart_rx_ready), 32'd1);
        check("reset_tx_valid", 32'(uart_tx_valid), 32'd0);

        // Two stores, then one-cycle drain
        store(4'h8, 32'h41);
        store(4'h8, 32'h42);
        check("tx2_valid", 32'(uart_tx_valid), 32'd1);
        check("tx2_head", 32'(uart_tx_data), 32'h41);
        load(4'h0);
        check("tx2_count", (mmio_rdata >> 16) & 32'hF, 32'd2);
        uart_tx_ready = 1'b1;
        tick();
        uart_tx_ready = 1'b0;
        check("tx1_head", 32'(uart_tx_data), 32'h42);
        load(4'h0);
        check("tx1_count", (mmio_rdata >> 16) & 32'hF, 32'd1);
        uart_tx_ready = 1'b1;
        repeat (3) tick();
        uart_tx_ready = 1'b0;

        // Overflow: 9 stores into depth 8
        for (int i = 0; i < 9; i++) store(4'h8, 32'(8'h60 + i));
        load(4'h0);
        check("ovf_set", (mmio_rdata >> 2) & 32'h1, 32'd1);
        check("ovf_tx_count", (mmio_rdata >> 16) & 32'hF, 32'd8);
        check("ovf_not_full", mmio_rdata & 32'h1, 32'd0);
        store(4'h0, 32'h4);
        load(4'h0);
        check("ovf_cleared", (mmio_rdata >> 2) & 32'h1, 32'd0);
        fires0 = tx_fires;
        uart_tx_ready = 1'b1;
        repeat (12) tick();
        uart_tx_ready = 1'b0;
        check("ovf_drain_count", 32'(tx_fires - fires0), 32'd8);

        // RX fill to full, then pop in order
        for (int i = 0; i < 8; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data  = 8'(8'h10 + i);
            tick();
        end
        check("rx_full_ready", 32'(uart_rx_ready), 32'd0);
        uart_rx_data = 8'h18;
        repeat (2) tick();
        for (int i = 0; i < 9; i++) begin
            load(4'h4);
            check("rx_order", mmio_rdata, 32'(8'h10 + i));
            if (i == 0) check("rx_ready_after_pop", 32'(uart_rx_ready), 32'd1);
            if (i == 1) uart_rx_valid = 1'b0;
        end

        // Empty read and simultaneous push/pop at count 3
        load(4'h4);
        check("rx_empty_read", mmio_rdata, 32'd0);
        load(4'h0);
        check("rx_empty_count", (mmio_rdata >> 8) & 32'hF, 32'd0);
        for (int i = 0; i < 3; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data  = 8'(8'h20 + i);
            tick();
        end
        uart_rx_data = 8'h23;
        load(4'h4);
        uart_rx_valid = 1'b0;
        check("rx_pushpop_data", mmio_rdata, 32'h20);
        load(4'h0);
        check("rx_pushpop_count", (mmio_rdata >> 8) & 32'hF, 32'd3);
        for (int i = 1; i < 4; i++) begin
            load(4'h4);
            check("rx_pushpop_order", mmio_rdata, 32'(8'h20 + i));
        end

        // Reset mid-operation
        for (int i = 0; i < 5; i++) store(4'h8, 32'(8'hA0 + i));
        for (int i = 0; i < 3; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data  = 8'(8'hB0 + i);
            tick();
        end
        uart_rx_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
        check("rst_rx_ready", 32'(uart_rx_ready), 32'd1);
        load(4'h0);
        check("rst_status", mmio_rdata, 32'h0000_0001);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] a;
            a = 4'(($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            reset         = ($urandom_range(0, 499) == 0);
            uart_rx_valid = $urandom_range(0, 1) == 1;
            uart_rx_data  = 8'($urandom);
            uart_tx_ready = $urandom_range(0, 3) == 0;
            mmio_we       = $urandom_range(0, 2) == 0;
            mmio_re       = $urandom_range(0, 2) == 0;
            mmio_addr     = mmio_we && ($urandom_range(0, 1) == 1) ? 4'h8 : a;
            mmio_wdata    = $urandom;
            tick();
        end
        reset         = 1'b0;
        mmio_we       = 1'b0;
        mmio_re       = 1'b0;
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b1;
        repeat (12) tick();
        check("final_tx_drained", 32'(exp_tx.size()), 32'd0);
        check("final_rd_consumed", 32'(exp_rd.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
